// File: rtl/dft_bin_scheduler.sv
// dft_bin_scheduler
//   Sequencer in front of a serial single-bin DFT accumulator and its twiddle
//   ROM. One frame of FRAME_LENGTH multi-channel samples is buffered, then
//   replayed once per bin k = 0..NUM_BINS-1 with the twiddle address n*k mod N
//   issued alongside each sample. Each bin's accumulator result is captured
//   and offered downstream on a valid/ready stream tagged with k.
//
// Ports
//   clk, rst            clock (posedge) and synchronous active-high reset
//   s_valid/s_ready/s_x sample input stream; accepted only while filling
//   dp_valid/dp_x       replayed samples to the accumulator (one per cycle)
//   tw_addr             twiddle ROM address, aligned with dp_x
//   dp_re/dp_im/dp_done accumulator results and their completion strobe
//   m_valid/m_ready     bin result stream handshake
//   m_bin/m_re/m_im     bin index and captured real/imag results
//   busy                high whenever the scheduler is not filling
//   err                 sticky: unexpected dp_done or missing dp_done
module dft_bin_scheduler #(
  parameter int  X_WIDTH      = 16,
  parameter int  S_WIDTH      = 32,
  parameter int  FRAME_LENGTH = 8,
  parameter int  NUM_BINS     = 4,
  parameter int  CHANELS      = 2,
  localparam int AW           = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1,
  localparam int BW           = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CHANELS*X_WIDTH-1:0] s_x,
  output logic                       dp_valid,
  output logic [CHANELS*X_WIDTH-1:0] dp_x,
  output logic [AW-1:0]              tw_addr,
  input  logic [CHANELS*S_WIDTH-1:0] dp_re,
  input  logic [CHANELS*S_WIDTH-1:0] dp_im,
  input  logic                       dp_done,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BW-1:0]              m_bin,
  output logic [CHANELS*S_WIDTH-1:0] m_re,
  output logic [CHANELS*S_WIDTH-1:0] m_im,
  output logic                       busy,
  output logic                       err
);

  localparam logic [AW-1:0] N_LAST = AW'(FRAME_LENGTH - 1);
  localparam logic [BW-1:0] K_LAST = BW'(NUM_BINS - 1);
  localparam logic [AW:0]   N_FULL = (AW + 1)'(FRAME_LENGTH);

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_WAIT, ST_OUT} state_t;

  state_t                     state;
  logic [AW-1:0]              n;
  logic [AW-1:0]              phase;
  logic [BW-1:0]              k;
  logic [1:0]                 wait_cnt;
  logic [CHANELS*X_WIDTH-1:0] frame_buf [FRAME_LENGTH];

  logic [AW:0]                phase_sum;
  logic [AW-1:0]              phase_next;

  // Twiddle phase advances by k each sample; k < N so a single conditional
  // subtract keeps it in [0, N) without a multiplier.
  always_comb begin
    phase_sum  = {1'b0, phase} + (AW + 1)'(k);
    phase_next = phase_sum[AW-1:0];
    if (phase_sum >= N_FULL) begin
      phase_next = AW'(phase_sum - N_FULL);
    end
  end

  assign s_ready = (state == ST_FILL);
  assign busy    = (state != ST_FILL);

  // ---- frame buffer write / replay read (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (s_valid && (state == ST_FILL)) begin
      frame_buf[n] <= s_x;
    end
    if (state == ST_RUN) begin
      dp_x <= frame_buf[n];
    end
  end

  // ---- sequencing FSM and registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      n        <= '0;
      k        <= '0;
      phase    <= '0;
      wait_cnt <= '0;
      dp_valid <= 1'b0;
      tw_addr  <= '0;
      m_valid  <= 1'b0;
      m_bin    <= '0;
      m_re     <= '0;
      m_im     <= '0;
      err      <= 1'b0;
    end else begin
      dp_valid <= 1'b0;
      // A completion strobe is only legal while waiting for one.
      if (dp_done && (state != ST_WAIT)) begin
        err <= 1'b1;
      end
      case (state)
        ST_FILL: begin
          if (s_valid) begin
            if (n == N_LAST) begin
              n     <= '0;
              k     <= '0;
              phase <= '0;
              state <= ST_RUN;
            end else begin
              n <= n + AW'(1);
            end
          end
        end
        ST_RUN: begin
          dp_valid <= 1'b1;
          tw_addr  <= phase;
          phase    <= phase_next;
          if (n == N_LAST) begin
            n        <= '0;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            n <= n + AW'(1);
          end
        end
        ST_WAIT: begin
          if (dp_done) begin
            m_re    <= dp_re;
            m_im    <= dp_im;
            m_bin   <= k;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else if (wait_cnt == 2'd3) begin
            // Accumulator never answered: flag it and drop the frame.
            err   <= 1'b1;
            n     <= '0;
            state <= ST_FILL;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            n       <= '0;
            if (k == K_LAST) begin
              state <= ST_FILL;
            end else begin
              k     <= k + BW'(1);
              phase <= '0;
              state <= ST_RUN;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_bin_scheduler.sv
// tb_dft_bin_scheduler
//   Directed bench for dft_bin_scheduler with N=8, 4 bins, 2 channels.
//   A behavioural single-bin accumulator (Q15 cos / -sin ROM, done one cycle
//   after the last sample) closes the loop around the scheduler.
module tb_dft_bin_scheduler;

  localparam int XW = 16;
  localparam int SW = 32;
  localparam int N  = 8;
  localparam int NB = 4;
  localparam int CH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [CH*XW-1:0]  s_x;
  logic              dp_valid;
  logic [CH*XW-1:0]  dp_x;
  logic [2:0]        tw_addr;
  logic [CH*SW-1:0]  dp_re;
  logic [CH*SW-1:0]  dp_im;
  logic              dp_done;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        m_bin;
  logic [CH*SW-1:0]  m_re;
  logic [CH*SW-1:0]  m_im;
  logic              busy;
  logic              err;

  int total = 0;
  int bad   = 0;
  int hs_total = 0;
  int hs_snap;

  logic suppress;
  logic inject;

  logic [15:0] f0 [N];
  logic [15:0] f1 [N];

  always #5 clk = ~clk;

  dft_bin_scheduler #(
    .X_WIDTH(XW), .S_WIDTH(SW), .FRAME_LENGTH(N), .NUM_BINS(NB), .CHANELS(CH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
    .dp_valid(dp_valid), .dp_x(dp_x), .tw_addr(tw_addr),
    .dp_re(dp_re), .dp_im(dp_im), .dp_done(dp_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin),
    .m_re(m_re), .m_im(m_im),
    .busy(busy), .err(err)
  );

  // Q15 twiddles: cos(2*pi*m/8) and -sin(2*pi*m/8)
  logic signed [15:0] cos_rom [N] = '{16'sd32767, 16'sd23170, 16'sd0, -16'sd23170,
                                      -16'sd32767, -16'sd23170, 16'sd0, 16'sd23170};
  logic signed [15:0] msin_rom [N] = '{16'sd0, -16'sd23170, -16'sd32767, -16'sd23170,
                                       16'sd0, 16'sd23170, 16'sd32767, 16'sd23170};

  // Hand-written n*k mod 8 address tables per bin
  int tw_exp [NB][N] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                         '{0, 1, 2, 3, 4, 5, 6, 7},
                         '{0, 2, 4, 6, 0, 2, 4, 6},
                         '{0, 3, 6, 1, 4, 7, 2, 5}};

  // Behavioural accumulator
  logic signed [31:0] acc_re [CH];
  logic signed [31:0] acc_im [CH];
  logic signed [31:0] sum_re [CH];
  logic signed [31:0] sum_im [CH];
  int   acc_n;
  logic done_q;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_re[c] = acc_re[c] + $signed(dp_x[c*XW +: XW]) * cos_rom[tw_addr];
      sum_im[c] = acc_im[c] + $signed(dp_x[c*XW +: XW]) * msin_rom[tw_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      acc_n  <= 0;
      done_q <= 1'b0;
      dp_re  <= '0;
      dp_im  <= '0;
      for (int c = 0; c < CH; c++) begin
        acc_re[c] <= '0;
        acc_im[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (dp_valid) begin
        if (acc_n == N - 1) begin
          acc_n  <= 0;
          done_q <= 1'b1;
          for (int c = 0; c < CH; c++) begin
            dp_re[c*SW +: SW] <= sum_re[c];
            dp_im[c*SW +: SW] <= sum_im[c];
            acc_re[c] <= '0;
            acc_im[c] <= '0;
          end
        end else begin
          acc_n <= acc_n + 1;
          for (int c = 0; c < CH; c++) begin
            acc_re[c] <= sum_re[c];
            acc_im[c] <= sum_im[c];
          end
        end
      end
    end
  end

  assign dp_done = (done_q && !suppress) || inject;

  always @(posedge clk) begin
    if (!rst && s_valid && s_ready) hs_total <= hs_total + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [63:0] obs);
    total++;
    assert ((obs >= -8 && obs <= 8) === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=0+-8", tag, obs);
    end
  endtask

  task automatic fill_frame();
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_x     = {f1[i], f0[i]};
      chk($sformatf("fill_ready_%0d", i), s_ready, 1);
      step();
    end
    chk("fill_done_ready", s_ready, 0);
    chk("fill_done_busy", busy, 1);
    chk("first_dp_not_yet", dp_valid, 0);
  endtask

  task automatic run_bin(input int k);
    for (int i = 0; i < N; i++) begin
      step();
      chk($sformatf("dp_valid_k%0d_n%0d", k, i), dp_valid, 1);
      chk($sformatf("tw_addr_k%0d_n%0d", k, i), tw_addr, tw_exp[k][i]);
      chk($sformatf("dp_x0_k%0d_n%0d", k, i), dp_x[15:0], f0[i]);
      chk($sformatf("dp_x1_k%0d_n%0d", k, i), dp_x[31:16], f1[i]);
    end
    step();
    chk($sformatf("wait_dp_k%0d", k), dp_valid, 0);
    chk($sformatf("wait_mv_k%0d", k), m_valid, 0);
    step();
    chk($sformatf("m_valid_k%0d", k), m_valid, 1);
    chk($sformatf("m_bin_k%0d", k), m_bin, k);
  endtask

  task automatic chk_res(input int k, input int re0, input int im0,
                         input int re1, input int im1);
    chk($sformatf("re0_k%0d", k), $signed(m_re[31:0]), re0);
    chk($sformatf("im0_k%0d", k), $signed(m_im[31:0]), im0);
    chk($sformatf("re1_k%0d", k), $signed(m_re[63:32]), re1);
    chk($sformatf("im1_k%0d", k), $signed(m_im[63:32]), im1);
  endtask

  task automatic accept(input int k);
    step();
    chk($sformatf("accept_mv_k%0d", k), m_valid, 0);
    chk($sformatf("accept_dp_k%0d", k), dp_valid, 0);
  endtask

  int a_re0 [NB] = '{917476, -131068, -131068, -131068};
  int a_im0 [NB] = '{0, 316428, 131068, 54292};
  int a_re1 [NB] = '{1834952, -262136, -262136, -262136};
  int a_im1 [NB] = '{0, 632856, 262136, 108584};

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_x = '0; m_ready = 1'b1;
    suppress = 1'b0; inject = 1'b0;
    step(); step();

    // Reset state
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_m_bin", m_bin, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    rst = 1'b0;

    // Frame A: ramp on ch0, doubled ramp on ch1; s_valid never drops
    for (int i = 0; i < N; i++) begin
      f0[i] = 16'(i);
      f1[i] = 16'(2 * i);
    end
    hs_snap = hs_total;
    fill_frame();
    s_x = {16'h5A5A, 16'h7FFF};
    for (int k = 0; k < NB; k++) begin
      run_bin(k);
      chk_res(k, a_re0[k], a_im0[k], a_re1[k], a_im1[k]);
      accept(k);
    end
    chk("a_refill_ready", s_ready, 1);
    chk("a_refill_busy", busy, 0);
    chk("a_accepted_count", hs_total - hs_snap, 8);

    // Frame B: ch0 = 1, ch1 = 0; backpressure on bin 1
    for (int i = 0; i < N; i++) begin
      f0[i] = 16'd1;
      f1[i] = 16'd0;
    end
    fill_frame();
    s_valid = 1'b0;
    run_bin(0);
    chk_res(0, 262136, 0, 0, 0);
    accept(0);
    m_ready = 1'b0;
    run_bin(1);
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("stall_mv_%0d", j), m_valid, 1);
      chk($sformatf("stall_bin_%0d", j), m_bin, 1);
      chk_near($sformatf("stall_re0_%0d", j), $signed(m_re[31:0]));
      chk($sformatf("stall_re1_%0d", j), $signed(m_re[63:32]), 0);
      chk($sformatf("stall_dp_%0d", j), dp_valid, 0);
    end
    m_ready = 1'b1;
    accept(1);
    for (int k = 2; k < NB; k++) begin
      run_bin(k);
      chk_near($sformatf("b_re0_k%0d", k), $signed(m_re[31:0]));
      chk_near($sformatf("b_im0_k%0d", k), $signed(m_im[31:0]));
      chk($sformatf("b_re1_k%0d", k), $signed(m_re[63:32]), 0);
      chk($sformatf("b_im1_k%0d", k), $signed(m_im[63:32]), 0);
      accept(k);
    end
    chk("b_end_ready", s_ready, 1);

    // Spurious dp_done while filling
    chk("pre_inject_err", err, 0);
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("inject_err", err, 1);
    chk("inject_ready", s_ready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clears_err", err, 0);

    // Frame C: accumulator never answers
    for (int i = 0; i < N; i++) begin
      f0[i] = 16'(i + 3);
      f1[i] = 16'd0;
    end
    suppress = 1'b1;
    fill_frame();
    s_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      step();
      chk($sformatf("c_dp_valid_%0d", i), dp_valid, 1);
    end
    step();
    chk("c_wait_dp", dp_valid, 0);
    step(); step();
    chk("c_wait3_busy", busy, 1);
    chk("c_wait3_err", err, 0);
    step();
    chk("c_timeout_err", err, 1);
    chk("c_timeout_ready", s_ready, 1);
    chk("c_timeout_mv", m_valid, 0);
    suppress = 1'b0;

    // Frame D: reset in the middle of replay
    for (int i = 0; i < N; i++) begin
      f0[i] = 16'(10 * i);
      f1[i] = 16'd0;
    end
    fill_frame();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("d_run_dp", dp_valid, 1);
    chk("d_run_x", dp_x[15:0], 30);
    chk("d_err_sticky", err, 1);
    rst = 1'b1;
    step();
    chk("d_rst_dp", dp_valid, 0);
    chk("d_rst_ready", s_ready, 1);
    chk("d_rst_err", err, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_tw", tw_addr, 0);
    rst = 1'b0;
    step();
    chk("d_post_ready", s_ready, 1);
    chk("d_post_dp", dp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
